// File: rtl/iot_riscv_trap_if.sv
// ID/LSU/CSR/fetch signal bundle for the machine-mode trap sequencer.
// master drives the core-side inputs, slave is the sequencer itself.
interface iot_riscv_trap_if #(
    parameter int pc_size_p = 32
);
    logic                 id_valid_i;
    logic [pc_size_p-1:0] id_pc_i;
    logic                 ecall_i;
    logic                 ebreak_i;
    logic                 illegal_i;
    logic                 mret_i;
    logic                 irq_i;
    logic                 lsu_busy_i;
    logic [11:0]          ex_csr_addr_i;
    logic                 ex_csr_we_i;
    logic [31:0]          ex_alu_res_i;
    logic [31:0]          mtvec_i;
    logic [31:0]          mepc_i;
    logic                 redirect_ready_i;
    logic                 trap_flush_o;
    logic                 redirect_valid_o;
    logic [31:0]          redirect_pc_o;
    logic                 mepc_we_o;
    logic [31:0]          mepc_wdata_o;
    logic                 busy_o;
    logic [31:0]          csr_rd_value_o;

    modport master (
        output id_valid_i, id_pc_i, ecall_i, ebreak_i, illegal_i, mret_i, irq_i,
               lsu_busy_i, ex_csr_addr_i, ex_csr_we_i, ex_alu_res_i, mtvec_i,
               mepc_i, redirect_ready_i,
        input  trap_flush_o, redirect_valid_o, redirect_pc_o, mepc_we_o,
               mepc_wdata_o, busy_o, csr_rd_value_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, ecall_i, ebreak_i, illegal_i, mret_i, irq_i,
               lsu_busy_i, ex_csr_addr_i, ex_csr_we_i, ex_alu_res_i, mtvec_i,
               mepc_i, redirect_ready_i,
        output trap_flush_o, redirect_valid_o, redirect_pc_o, mepc_we_o,
               mepc_wdata_o, busy_o, csr_rd_value_o
    );
endinterface

// File: rtl/iot_riscv_trap.sv
// Machine-mode trap/mret sequencer: IDLE -> DRAIN -> COMMIT -> REDIRECT, 3 cycles event to redirect.
// DRAIN waits on lsu_busy_i; REDIRECT holds valid/pc until fetch asserts redirect_ready_i.
module iot_riscv_trap #(
    parameter int pc_size_p = 32
) (
    input logic             main_clk_i,
    input logic             main_rst_i,
    iot_riscv_trap_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [11:0] csr_mstatus_c = 12'h300;
    localparam logic [11:0] csr_mie_c     = 12'h304;
    localparam logic [11:0] csr_mcause_c  = 12'h342;
    localparam logic [31:0] cause_irq_c   = 32'h8000_000B;
    localparam logic [31:0] cause_ill_c   = 32'd2;
    localparam logic [31:0] cause_brk_c   = 32'd3;
    localparam logic [31:0] cause_ecall_c = 32'd11;

    state_t               state_q, state_d;
    logic                 mie_q, mpie_q, meie_q;
    logic [31:0]          mcause_q;
    logic [31:0]          cap_cause_q;
    logic [31:0]          cap_pc_q;
    logic                 cap_mret_q;

    logic [pc_size_p-1:0] id_pc;
    logic [31:0]          pc_ext;
    logic                 irq_take;
    logic                 trap_ev;
    logic                 mret_ev;
    logic [31:0]          ev_cause;

    logic                 trap_flush;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic                 mepc_we;
    logic [31:0]          mepc_wdata;
    logic [31:0]          csr_rd_value;
    logic                 unused_low_bits;

    assign id_pc  = bus.id_pc_i;
    assign pc_ext = 32'(id_pc);

    // Targets are word aligned; the low bits of mtvec/mepc never reach fetch.
    assign unused_low_bits = ^{bus.mtvec_i[1:0], bus.mepc_i[1:0]};

    always_comb begin
        irq_take = bus.irq_i & mie_q & meie_q;
        trap_ev  = 1'b1;
        ev_cause = 32'd0;
        if (irq_take) begin
            ev_cause = cause_irq_c;
        end else if (bus.id_valid_i && bus.illegal_i) begin
            ev_cause = cause_ill_c;
        end else if (bus.id_valid_i && bus.ebreak_i) begin
            ev_cause = cause_brk_c;
        end else if (bus.id_valid_i && bus.ecall_i) begin
            ev_cause = cause_ecall_c;
        end else begin
            trap_ev = 1'b0;
        end
        mret_ev = ~trap_ev & bus.id_valid_i & bus.mret_i;
    end

    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            state_q     <= IDLE;
            cap_cause_q <= 32'd0;
            cap_pc_q    <= 32'd0;
            cap_mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (trap_ev || mret_ev)) begin
                cap_cause_q <= ev_cause;
                cap_pc_q    <= pc_ext;
                cap_mret_q  <= mret_ev;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        trap_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mepc_we        = 1'b0;
        mepc_wdata     = 32'd0;
        case (state_q)
            IDLE: begin
                if (trap_ev || mret_ev) state_d = DRAIN;
            end
            DRAIN: begin
                trap_flush = 1'b1;
                if (!bus.lsu_busy_i) state_d = COMMIT;
            end
            COMMIT: begin
                trap_flush = 1'b1;
                mepc_we    = ~cap_mret_q;
                mepc_wdata = cap_mret_q ? 32'd0 : cap_pc_q;
                state_d    = REDIRECT;
            end
            REDIRECT: begin
                trap_flush     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = cap_mret_q ? {bus.mepc_i[31:2], 2'b00}
                                            : {bus.mtvec_i[31:2], 2'b00};
                if (bus.redirect_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The COMMIT-cycle architectural update takes precedence over any EX CSR write.
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mcause_q <= 32'd0;
        end else if (state_q == COMMIT) begin
            if (cap_mret_q) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else begin
                mcause_q <= cap_cause_q;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end
        end else if (bus.ex_csr_we_i) begin
            case (bus.ex_csr_addr_i)
                csr_mstatus_c: begin
                    mie_q  <= bus.ex_alu_res_i[3];
                    mpie_q <= bus.ex_alu_res_i[7];
                end
                csr_mie_c:    meie_q   <= bus.ex_alu_res_i[11];
                csr_mcause_c: mcause_q <= bus.ex_alu_res_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rd_value = 32'd0;
        case (bus.ex_csr_addr_i)
            csr_mstatus_c: begin
                csr_rd_value[3]     = mie_q;
                csr_rd_value[7]     = mpie_q;
                csr_rd_value[12:11] = 2'b11;
            end
            csr_mie_c:    csr_rd_value[11] = meie_q;
            csr_mcause_c: csr_rd_value     = mcause_q;
            default: ;
        endcase
    end

    assign bus.trap_flush_o     = trap_flush;
    assign bus.redirect_valid_o = redirect_valid;
    assign bus.redirect_pc_o    = redirect_pc;
    assign bus.mepc_we_o        = mepc_we;
    assign bus.mepc_wdata_o     = mepc_wdata;
    assign bus.busy_o           = (state_q != IDLE);
    assign bus.csr_rd_value_o   = csr_rd_value;
endmodule

// File: tb/tb_iot_riscv_trap.sv
// Scoreboard bench for iot_riscv_trap: directed cases plus randomized events against a CSR/trap model.
module tb_iot_riscv_trap;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iot_riscv_trap_if #(.pc_size_p(32)) bus();
    iot_riscv_trap #(.pc_size_p(32)) dut (
        .main_clk_i(clk),
        .main_rst_i(rst),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_mepc_q[$];
    logic [31:0] exp_redir_q[$];

    bit          m_mie, m_mpie, m_meie;
    logic [31:0] m_mcause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [31:0] r;
        r = 32'd0;
        if (a == 12'h300) r = {19'd0, 2'b11, 3'd0, m_mpie, 3'd0, m_mie, 3'd0};
        else if (a == 12'h304) r = {20'd0, m_meie, 11'd0};
        else if (a == 12'h342) r = m_mcause;
        return r;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_mcause = 32'd0;
    endtask

    // Monitor: pops expectations whenever the DUT presents a mepc write or a redirect handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mepc_we_o) begin
                    if (exp_mepc_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL mepc_we_unexpected: got 1 expected 0 at %0t", $time);
                    end else begin
                        check("mepc_wdata", bus.mepc_wdata_o, exp_mepc_q.pop_front());
                    end
                end
                if (bus.redirect_valid_o && bus.redirect_ready_i) begin
                    if (exp_redir_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL redirect_unexpected: got %h expected none at %0t",
                                 bus.redirect_pc_o, $time);
                    end else begin
                        check("redirect_pc", bus.redirect_pc_o, exp_redir_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic csr_check(input logic [11:0] a);
        bus.ex_csr_addr_i = a;
        #1;
        check($sformatf("csr_rd_%h", a), bus.csr_rd_value_o, model_read(a));
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.ex_csr_we_i = 1; bus.ex_csr_addr_i = a; bus.ex_alu_res_i = d;
        @(posedge clk); #1;
        bus.ex_csr_we_i = 0;
        if (a == 12'h300) begin m_mie = d[3]; m_mpie = d[7]; end
        else if (a == 12'h304) m_meie = d[11];
        else if (a == 12'h342) m_mcause = d;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, {31'd0, bus.busy_o}, 32'd0);
        check({tag, "_flush"}, {31'd0, bus.trap_flush_o}, 32'd0);
        check({tag, "_valid"}, {31'd0, bus.redirect_valid_o}, 32'd0);
    endtask

    // b = lsu busy cycles in DRAIN, s = cycles with ready low in REDIRECT.
    task automatic run_event(input bit v, input bit ec, input bit eb, input bit il,
                             input bit mr, input bit iq, input logic [31:0] pc,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input int b, input int s, input bit inj_mret,
                             input bit csr_commit, input bit rst_redir);
        bit take_irq, trap, is_mret;
        logic [31:0] cause, exp_pc;
        take_irq = iq && m_mie && m_meie;
        trap     = take_irq || (v && (il || eb || ec));
        is_mret  = !trap && v && mr;
        cause    = take_irq ? 32'h8000_000B : il ? 32'd2 : eb ? 32'd3 : 32'd11;
        exp_pc   = trap ? {mtvec[31:2], 2'b00} : {mepc[31:2], 2'b00};

        @(posedge clk); #1;
        bus.id_valid_i = v; bus.ecall_i = ec; bus.ebreak_i = eb; bus.illegal_i = il;
        bus.mret_i = mr; bus.irq_i = iq; bus.id_pc_i = pc;
        bus.mtvec_i = mtvec; bus.mepc_i = mepc; bus.lsu_busy_i = (b > 0);
        @(posedge clk); #1;
        bus.id_valid_i = 0; bus.ecall_i = 0; bus.ebreak_i = 0; bus.illegal_i = 0;
        bus.mret_i = 0; bus.irq_i = 0;

        if (!trap && !is_mret) begin
            bus.lsu_busy_i = 0;
            repeat (3) begin
                @(negedge clk);
                check_quiet("no_event");
            end
            return;
        end

        if (trap) exp_mepc_q.push_back(pc);
        if (!rst_redir) exp_redir_q.push_back(exp_pc);

        for (int n = 1; n <= b + 3 + s; n++) begin
            bus.lsu_busy_i       = (n <= b);
            bus.redirect_ready_i = (n >= b + 3 + s) && !rst_redir;
            bus.ex_csr_we_i      = csr_commit && (n == b + 2);
            bus.ex_csr_addr_i    = 12'h342;
            bus.ex_alu_res_i     = 32'h5A5A_0F0F;
            bus.id_valid_i       = inj_mret && (n == b + 3);
            bus.mret_i           = inj_mret && (n == b + 3);
            @(negedge clk);
            check("seq_busy", {31'd0, bus.busy_o}, 32'd1);
            check("seq_flush", {31'd0, bus.trap_flush_o}, 32'd1);
            check("seq_valid", {31'd0, bus.redirect_valid_o}, {31'd0, n >= b + 3});
            check("seq_mepc_we", {31'd0, bus.mepc_we_o}, {31'd0, trap && (n == b + 2)});
            if (n >= b + 3) check("seq_redir_hold", bus.redirect_pc_o, exp_pc);
            @(posedge clk); #1;
        end
        bus.ex_csr_we_i = 0; bus.id_valid_i = 0; bus.mret_i = 0; bus.lsu_busy_i = 0;

        if (trap) begin
            m_mcause = cause; m_mpie = m_mie; m_mie = 0;
        end else begin
            m_mie = m_mpie; m_mpie = 1;
        end

        if (rst_redir) begin
            @(negedge clk);
            check("stall_valid", {31'd0, bus.redirect_valid_o}, 32'd1);
            check("stall_pc", bus.redirect_pc_o, exp_pc);
            rst = 1;
            #1;
            check("rst_flush", {31'd0, bus.trap_flush_o}, 32'd0);
            check("rst_valid", {31'd0, bus.redirect_valid_o}, 32'd0);
            check("rst_pc", bus.redirect_pc_o, 32'd0);
            check("rst_mepc_we", {31'd0, bus.mepc_we_o}, 32'd0);
            check("rst_wdata", bus.mepc_wdata_o, 32'd0);
            check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
            model_reset();
            @(negedge clk);
            rst = 0;
            csr_check(12'h342);
            csr_check(12'h300);
        end else begin
            bus.redirect_ready_i = 0;
            repeat (3) begin
                @(negedge clk);
                check_quiet("post_seq");
            end
        end
    endtask

    initial begin
        bus.id_valid_i = 0; bus.id_pc_i = 0; bus.ecall_i = 0; bus.ebreak_i = 0;
        bus.illegal_i = 0; bus.mret_i = 0; bus.irq_i = 0; bus.lsu_busy_i = 0;
        bus.ex_csr_addr_i = 0; bus.ex_csr_we_i = 0; bus.ex_alu_res_i = 0;
        bus.mtvec_i = 0; bus.mepc_i = 0; bus.redirect_ready_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_flush", {31'd0, bus.trap_flush_o}, 32'd0);
        check("reset_valid", {31'd0, bus.redirect_valid_o}, 32'd0);
        check("reset_pc", bus.redirect_pc_o, 32'd0);
        check("reset_mepc_we", {31'd0, bus.mepc_we_o}, 32'd0);
        check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        csr_check(12'h000);
        csr_check(12'h300);
        csr_check(12'h304);
        csr_check(12'h342);
        @(negedge clk);
        rst = 0;

        // ecall at 0x100 into mtvec 0x200
        run_event(1, 1, 0, 0, 0, 0, 32'h100, 32'h200, 32'h0, 0, 0, 0, 0, 0);
        csr_check(12'h342);
        // irq masked, then enabled
        run_event(0, 0, 0, 0, 0, 1, 32'h104, 32'h200, 32'h0, 0, 0, 0, 0, 0);
        csr_write(12'h300, 32'h8);
        csr_write(12'h304, 32'h800);
        csr_check(12'h300);
        run_event(0, 0, 0, 0, 0, 1, 32'h108, 32'h301, 32'h0, 0, 0, 0, 0, 0);
        csr_check(12'h342);
        csr_check(12'h300);
        // simultaneous illegal/ebreak/ecall; mret injected while redirect stalled
        run_event(1, 1, 1, 1, 0, 0, 32'h10C, 32'h400, 32'h0, 0, 2, 1, 0, 0);
        csr_check(12'h342);
        // LSU busy for 5 cycles
        run_event(1, 1, 0, 0, 0, 0, 32'h110, 32'h500, 32'h0, 5, 0, 0, 0, 0);
        // mret with MPIE=1
        csr_write(12'h300, 32'h80);
        run_event(1, 0, 0, 0, 1, 0, 32'h114, 32'h500, 32'h123, 0, 0, 0, 0, 0);
        csr_check(12'h300);
        // CSR write landing in the COMMIT cycle is dropped
        run_event(1, 0, 1, 0, 0, 0, 32'h118, 32'h600, 32'h0, 1, 1, 0, 1, 0);
        csr_check(12'h342);
        // stall 4 cycles then reset in REDIRECT
        run_event(1, 1, 0, 0, 0, 0, 32'h11C, 32'h700, 32'h0, 0, 4, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                csr_write(12'h300, $urandom & 32'h0000_0088);
            if ($urandom_range(0, 2) == 0)
                csr_write(12'h304, $urandom & 32'h0000_0800);
            run_event(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                      $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            csr_check(12'h300);
            csr_check(12'h304);
            csr_check(12'h342);
        end

        repeat (2) @(negedge clk);
        check("mepc_queue_empty", exp_mepc_q.size(), 32'd0);
        check("redir_queue_empty", exp_redir_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
